// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a one-entry skid slot.
// Keeps full throughput while ReadyE depends only on registered state.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEMW_W = 4,
  parameter int MEMR_W = 2
) (
  input  logic              clk,
  input  logic              inicio,
  input  logic              ValidE,
  output logic              ReadyE,
  input  logic [MEMR_W-1:0] MemReadE,
  input  logic [MEMW_W-1:0] MemWriteE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteDataE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              StallM,
  input  logic              FlushM,
  output logic              ValidM,
  output logic [MEMR_W-1:0] MemReadM,
  output logic [MEMW_W-1:0] MemWriteM,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [REG_AW-1:0] WriteRegM
);

  typedef struct packed {
    logic [MEMR_W-1:0] mem_read;
    logic [MEMW_W-1:0] mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wdata;
    logic [REG_AW-1:0] wreg;
  } slot_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  slot_t  main_q;
  slot_t  skid_q;
  slot_t  e_slot;
  logic   accept;
  logic   consume;

  assign e_slot = '{
    mem_read:   MemReadE,
    mem_write:  MemWriteE,
    reg_write:  RegWriteE,
    mem_to_reg: MemtoRegE,
    alu_out:    ALUOut,
    wdata:      WriteDataE,
    wreg:       WriteRegE
  };

  assign ReadyE  = (state != FULL) & ~inicio;
  assign ValidM  = (state != EMPTY);
  assign accept  = ValidE & ReadyE;
  assign consume = ValidM & ~StallM;

  // A slot is zeroed whenever it goes invalid, so bubbles read as zero.
  always_ff @(posedge clk) begin
    if (inicio || FlushM) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= e_slot;
            state  <= ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept & consume: begin
              main_q <= e_slot;
            end
            accept & ~consume: begin
              skid_q <= e_slot;
              state  <= FULL;
            end
            ~accept & consume: begin
              main_q <= '0;
              state  <= EMPTY;
            end
            default: begin
            end
          endcase
        end
        FULL: begin
          if (consume) begin
            main_q <= skid_q;
            skid_q <= '0;
            state  <= ONE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

  assign MemReadM   = main_q.mem_read;
  assign MemWriteM  = main_q.mem_write;
  assign RegWriteM  = main_q.reg_write;
  assign MemtoRegM  = main_q.mem_to_reg;
  assign ALUOutM    = main_q.alu_out;
  assign WriteDataM = main_q.wdata;
  assign WriteRegM  = main_q.wreg;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: reset, streaming, skid, flush,
// bubble gating, mid-run reset and a 64-bit parameter instance.
module tb_ex_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        inicio;
  logic        ValidE, ReadyE;
  logic [1:0]  MemReadE;
  logic [3:0]  MemWriteE;
  logic        RegWriteE, MemtoRegE;
  logic [31:0] ALUOut, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        StallM, FlushM, ValidM;
  logic [1:0]  MemReadM;
  logic [3:0]  MemWriteM;
  logic        RegWriteM, MemtoRegM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;

  logic        w_ValidE, w_ReadyE, w_StallM, w_ValidM;
  logic [1:0]  w_MemReadE, w_MemReadM;
  logic [7:0]  w_MemWriteE, w_MemWriteM;
  logic        w_RegWriteE, w_RegWriteM;
  logic        w_MemtoRegE, w_MemtoRegM;
  logic [63:0] w_ALUOut, w_WriteDataE, w_ALUOutM, w_WriteDataM;
  logic [5:0]  w_WriteRegE, w_WriteRegM;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg dut (
    .clk(clk), .inicio(inicio),
    .ValidE(ValidE), .ReadyE(ReadyE),
    .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .ALUOut(ALUOut), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE),
    .StallM(StallM), .FlushM(FlushM), .ValidM(ValidM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM)
  );

  ex_mem_pipe_reg #(
    .DATA_W(64), .REG_AW(6), .MEMW_W(8), .MEMR_W(2)
  ) dut64 (
    .clk(clk), .inicio(inicio),
    .ValidE(w_ValidE), .ReadyE(w_ReadyE),
    .MemReadE(w_MemReadE), .MemWriteE(w_MemWriteE),
    .RegWriteE(w_RegWriteE), .MemtoRegE(w_MemtoRegE),
    .ALUOut(w_ALUOut), .WriteDataE(w_WriteDataE),
    .WriteRegE(w_WriteRegE),
    .StallM(w_StallM), .FlushM(1'b0), .ValidM(w_ValidM),
    .MemReadM(w_MemReadM), .MemWriteM(w_MemWriteM),
    .RegWriteM(w_RegWriteM), .MemtoRegM(w_MemtoRegM),
    .ALUOutM(w_ALUOutM), .WriteDataM(w_WriteDataM),
    .WriteRegM(w_WriteRegM)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    inicio = 1'b1; ValidE = 1'b1; ALUOut = 32'hDEADBEEF;
    MemReadE = 2'd1; MemWriteE = 4'h0;
    RegWriteE = 1'b1; MemtoRegE = 1'b0;
    WriteDataE = 32'h0; WriteRegE = 5'd7;
    StallM = 1'b0; FlushM = 1'b0;
    w_ValidE = 1'b0; w_StallM = 1'b0;
    w_MemReadE = 2'd0; w_MemWriteE = 8'h0;
    w_RegWriteE = 1'b0; w_MemtoRegE = 1'b0;
    w_ALUOut = 64'h0; w_WriteDataE = 64'h0;
    w_WriteRegE = 6'd0;

    // reset held two cycles with a valid E-side instruction
    tick(); tick();
    chk("rst_validm", 64'(ValidM), 64'd0);
    chk("rst_aluoutm", 64'(ALUOutM), 64'd0);
    chk("rst_regwritem", 64'(RegWriteM), 64'd0);
    chk("rst_memreadm", 64'(MemReadM), 64'd0);
    chk("rst_writeregm", 64'(WriteRegM), 64'd0);
    chk("rst_readye", 64'(ReadyE), 64'd0);
    inicio = 1'b0; ValidE = 1'b0;
    #1;
    chk("rst_release_readye", 64'(ReadyE), 64'd1);

    // streaming 1..4 with no stall
    ValidE = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ALUOut = 32'(i);
      tick();
      chk("stream_aluoutm", 64'(ALUOutM), 64'(i));
      chk("stream_validm", 64'(ValidM), 64'd1);
      chk("stream_readye", 64'(ReadyE), 64'd1);
    end
    chk("stream_regwritem", 64'(RegWriteM), 64'd1);
    ValidE = 1'b0;
    tick();
    chk("stream_drain_validm", 64'(ValidM), 64'd0);
    chk("stream_drain_regwritem", 64'(RegWriteM), 64'd0);

    // skid: A=10 then B=20 under stall
    ValidE = 1'b1; ALUOut = 32'd10;
    tick();
    chk("skid_a_out", 64'(ALUOutM), 64'd10);
    ALUOut = 32'd20; StallM = 1'b1;
    tick();
    chk("skid_full_readye", 64'(ReadyE), 64'd0);
    chk("skid_full_out", 64'(ALUOutM), 64'd10);
    ALUOut = 32'd99;
    tick();
    chk("skid_hold1_out", 64'(ALUOutM), 64'd10);
    tick();
    chk("skid_hold2_out", 64'(ALUOutM), 64'd10);
    chk("skid_hold2_readye", 64'(ReadyE), 64'd0);
    chk("skid_hold2_validm", 64'(ValidM), 64'd1);
    StallM = 1'b0; ValidE = 1'b0;
    tick();
    chk("skid_b_out", 64'(ALUOutM), 64'd20);
    chk("skid_b_readye", 64'(ReadyE), 64'd1);
    tick();
    chk("skid_empty_validm", 64'(ValidM), 64'd0);

    // flush from FULL with a concurrent E-side instruction
    ValidE = 1'b1; RegWriteE = 1'b1; MemWriteE = 4'hF;
    ALUOut = 32'd5; StallM = 1'b1;
    tick();
    ALUOut = 32'd6;
    tick();
    chk("flush_pre_readye", 64'(ReadyE), 64'd0);
    chk("flush_pre_memwritem", 64'(MemWriteM), 64'hF);
    ALUOut = 32'd30; FlushM = 1'b1;
    tick();
    chk("flush_validm", 64'(ValidM), 64'd0);
    chk("flush_regwritem", 64'(RegWriteM), 64'd0);
    chk("flush_memwritem", 64'(MemWriteM), 64'd0);
    chk("flush_aluoutm", 64'(ALUOutM), 64'd0);

    // flush overrides an accept while in ONE
    FlushM = 1'b0; ALUOut = 32'd7;
    tick();
    chk("flush_one_pre", 64'(ALUOutM), 64'd7);
    ALUOut = 32'd31; FlushM = 1'b1;
    tick();
    chk("flush_one_validm", 64'(ValidM), 64'd0);
    FlushM = 1'b0; ValidE = 1'b0; StallM = 1'b0;
    tick();
    chk("flush_after_validm", 64'(ValidM), 64'd0);
    chk("flush_after_aluoutm", 64'(ALUOutM), 64'd0);

    // bubble gating
    RegWriteE = 1'b1; MemWriteE = 4'h3;
    tick();
    chk("bubble_validm", 64'(ValidM), 64'd0);
    chk("bubble_regwritem", 64'(RegWriteM), 64'd0);
    chk("bubble_memwritem", 64'(MemWriteM), 64'd0);

    // reset while FULL and stalled
    ValidE = 1'b1; StallM = 1'b1; ALUOut = 32'd40;
    tick();
    ALUOut = 32'd41;
    tick();
    chk("midrst_pre_readye", 64'(ReadyE), 64'd0);
    inicio = 1'b1;
    #1;
    chk("midrst_readye", 64'(ReadyE), 64'd0);
    tick();
    chk("midrst_validm", 64'(ValidM), 64'd0);
    chk("midrst_aluoutm", 64'(ALUOutM), 64'd0);
    inicio = 1'b0; ValidE = 1'b0; StallM = 1'b0;
    #1;
    chk("midrst_release_readye", 64'(ReadyE), 64'd1);
    tick();
    chk("midrst_no_ghost", 64'(ValidM), 64'd0);

    // wide parameter instance
    w_ValidE = 1'b1;
    w_ALUOut = 64'h0123456789ABCDEF;
    w_WriteDataE = 64'hFEDCBA9876543210;
    w_WriteRegE = 6'd63; w_MemWriteE = 8'hFF;
    w_RegWriteE = 1'b1;
    tick();
    chk("w64_validm", 64'(w_ValidM), 64'd1);
    chk("w64_aluoutm", w_ALUOutM, 64'h0123456789ABCDEF);
    chk("w64_wdatam", w_WriteDataM, 64'hFEDCBA9876543210);
    chk("w64_writeregm", 64'(w_WriteRegM), 64'd63);
    chk("w64_memwritem", 64'(w_MemWriteM), 64'hFF);
    chk("w64_regwritem", 64'(w_RegWriteM), 64'd1);
    w_ValidE = 1'b0;
    tick();
    chk("w64_drain_memwritem", 64'(w_MemWriteM), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 32, ALU result and store-data width.
REQ-002 REG_AW, 5, destination register address width.
REQ-003 MEMW_W, 4, byte-enable width of the memory write control.
REQ-004 MEMR_W, 2, memory read mode width.
REQ-005 Ports SHALL be (name, direction, width, meaning): clk  in  1  single clock, all state updates on rising edge.
REQ-006 inicio  in  1  reset, synchronous and active-high.
REQ-007 ValidE  in  1  Execute stage presents a valid instruction.
REQ-008 ReadyE  out  1  block can accept the Execute stage instruction this cycle.
REQ-009 MemReadE/MemWriteE  in  MEMR_W/MEMW_W  memory read mode / byte write enables.
REQ-010 RegWriteE, MemtoRegE  in  1 each  writeback controls.
REQ-011 ALUOut, WriteDataE  in  DATA_W each  ALU result, store data.
REQ-012 WriteRegE  in  REG_AW  destination register.
REQ-013 StallM  in  1  Memory stage cannot consume its instruction this cycle.
REQ-014 FlushM  in  1  kill every instruction held in the block.
REQ-015 ValidM  out  1  Memory stage outputs hold a valid instruction.
REQ-016 MemReadM, MemWriteM, RegWriteM, MemtoRegM, ALUOutM, WriteDataM, WriteRegM  out  same widths as E-side  registered Memory stage fields.

Function
REQ-017 Block SHALL hold two slots: main (drives M outputs) and skid; occupancy state SHALL be EMPTY, ONE (main valid) or FULL (main and skid valid).
REQ-018 Accept SHALL occur when ValidE & ReadyE; consume SHALL occur when ValidM & ~StallM.
REQ-019 ReadyE SHALL equal (state != FULL) & ~inicio, derived only from registered state and inicio, never from StallM.
REQ-020 EMPTY: accept -> ONE, main loaded; no accept -> EMPTY.
REQ-021 ONE: accept & consume -> ONE, main reloaded from E; accept & ~consume -> FULL, skid loaded from E, main held; ~accept & consume -> EMPTY; ~accept & ~consume -> ONE, held.
REQ-022 FULL: consume -> ONE, main loaded from skid; ~consume -> FULL, both held.
REQ-023 Latency SHALL be one cycle: an instruction accepted at edge N SHALL appear on M outputs after edge N when main was empty or consumed at N.
REQ-024 Instruction order SHALL be preserved; no instruction SHALL be dropped or duplicated without FlushM.
REQ-025 ValidM SHALL be 1 exactly in states ONE and FULL.
REQ-026 When ValidM=0, MemReadM, MemWriteM, RegWriteM and MemtoRegM SHALL read 0 (bubble); ALUOutM, WriteDataM, WriteRegM are don't-care but SHALL be 0 after reset or flush.
REQ-027 FlushM SHALL force state EMPTY at the next edge, zero all main and skid fields, and override any same-cycle accept (accepted instruction discarded).
REQ-028 Holding under StallM SHALL keep every M output bit-stable.
REQ-029 All data fields SHALL pass through unmodified at their parameter width; no arithmetic is performed.

Reset
REQ-030 inicio=1 at an edge SHALL set state EMPTY and every output and internal field to 0, with priority over FlushM, StallM and accept.
REQ-031 Reset mid-operation (FULL, stalled) SHALL discard both slots; ReadyE SHALL be 0 during inicio and 1 in the first cycle after inicio falls.

Verification
REQ-032 Reset: hold inicio 2 cycles with ValidE=1, ALUOut=32'hDEADBEEF -> ValidM=0, all M outputs 0, ReadyE=0; after release ReadyE=1.
REQ-033 Streaming: ValidE=1 for 4 cycles, ALUOut=1,2,3,4, StallM=0 -> ALUOutM=1,2,3,4 on consecutive cycles, each one cycle after input, ReadyE stays 1.
REQ-034 Skid: send A=10, B=20 with StallM=1 from B's cycle for 3 cycles -> state FULL, ReadyE=0, ALUOutM=10 held; StallM=0 -> 10 then 20 delivered, ReadyE=1 one cycle after first consume.
REQ-035 Flush: state FULL holding RegWrite=1, MemWrite=4'hF, FlushM=1 with ValidE=1 ALUOut=30 -> next cycle ValidM=0, RegWriteM=0, MemWriteM=0, 30 never appears.
REQ-036 Bubble gating: ValidE=0 with RegWriteE=1, MemWriteE=4'h3 -> ValidM=0, RegWriteM=0, MemWriteM=0.
REQ-037 Parameter sweep: DATA_W=64, REG_AW=6, MEMW_W=8 -> ALUOutM=64'h0123456789ABCDEF, WriteRegM=6'd63, MemWriteM=8'hFF pass intact.
